control_unit: RTL and testbench

Multicycle control unit for the 16-bit bus-based processor datapath. It fetches one instruction per `Run` request and sequences the eight-register file, the `A` operand register, the ALU and its result register `G` over a shared 16-bit bus. It drives every bus-source select, every register load enable and the 3-bit ALU operation `sinal`, and raises `Done` on each instruction's last cycle. It sits beside the datapath top level and holds no data values; it only reads the instruction register.

---
 rtl/proc_pkg.sv | 55 +++++
 rtl/control_unit_if.sv | 33 +++
 rtl/dec3to8.sv | 18 +
 rtl/control_unit.sv | 138 +++++++++++++
 tb/tb_control_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit bus-based processor: widths, opcodes,
// ALU operation codes and the control-unit step states.
package proc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ULA_W  = 3;

  // Instruction steps; T0 doubles as idle/fetch.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_MV  = 4'h0;
  localparam logic [OP_W-1:0] OP_MVI = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_SLT = 4'h5;
  localparam logic [OP_W-1:0] OP_SLL = 4'h6;
  localparam logic [OP_W-1:0] OP_SRL = 4'h7;

  localparam logic [ULA_W-1:0] ULA_ADD = 3'b000;
  localparam logic [ULA_W-1:0] ULA_SUB = 3'b001;
  localparam logic [ULA_W-1:0] ULA_OR  = 3'b010;
  localparam logic [ULA_W-1:0] ULA_SLT = 3'b011;
  localparam logic [ULA_W-1:0] ULA_SLL = 3'b100;
  localparam logic [ULA_W-1:0] ULA_SRL = 3'b101;

  // True for the six three-step ALU opcodes.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SRL);
  endfunction

  // Opcode to ALU operation select.
  function automatic logic [ULA_W-1:0] ula_code(input logic [OP_W-1:0] op);
    logic [ULA_W-1:0] code;
    case (op)
      OP_ADD:  code = ULA_ADD;
      OP_SUB:  code = ULA_SUB;
      OP_OR:   code = ULA_OR;
      OP_SLT:  code = ULA_SLT;
      OP_SLL:  code = ULA_SLL;
      OP_SRL:  code = ULA_SRL;
      default: code = ULA_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the control unit and the datapath.
//   Run, IR           : datapath/host -> control unit
//   IRin, Rin, Rout,
//   Ain, Gin, Gout,
//   DINout, sinal,
//   Done              : control unit -> datapath
// master = control unit side, slave = datapath side.
interface control_unit_if;
  import proc_pkg::*;

  logic              Run;
  logic [DATA_W-1:0] IR;
  logic              IRin;
  logic [REG_N-1:0]  Rin;
  logic [REG_N-1:0]  Rout;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              DINout;
  logic [ULA_W-1:0]  sinal;
  logic              Done;

  modport master (
    input  Run, IR,
    output IRin, Rin, Rout, Ain, Gin, Gout, DINout, sinal, Done
  );

  modport slave (
    output Run, IR,
    input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, sinal, Done
  );

endinterface

// File: rtl/dec3to8.sv
// 3-bit index to one-hot 8-bit decoder with enable.
//   en  : enable; output is all zeros when low
//   sel : register index
//   y   : one-hot select
module dec3to8
  import proc_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [REG_N-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control unit: steps each instruction through T0..T3 and decodes
// the bus-source selects, register load enables and ALU op from state and IR.
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset; also forces all outputs low
//   bus   : control bundle (master side), see control_unit_if
module control_unit
  import proc_pkg::*;
(
  input  logic          Clock,
  input  logic          Reset,
  control_unit_if.master bus
);

  logic [OP_W-1:0]  opcode;
  logic [SEL_W-1:0] rx;
  logic [SEL_W-1:0] ry;
  logic             unused_ir;

  assign opcode    = bus.IR[15:12];
  assign rx        = bus.IR[11:9];
  assign ry        = bus.IR[8:6];
  assign unused_ir = ^bus.IR[5:0];

  state_t state_q;
  state_t state_d;

  logic             irin_c;
  logic             rin_en_c;
  logic             rout_en_c;
  logic [SEL_W-1:0] rout_sel_c;
  logic             ain_c;
  logic             gin_c;
  logic             gout_c;
  logic             dinout_c;
  logic [ULA_W-1:0] sinal_c;
  logic             done_c;

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= T0;
    else       state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    irin_c     = 1'b0;
    rin_en_c   = 1'b0;
    rout_en_c  = 1'b0;
    rout_sel_c = rx;
    ain_c      = 1'b0;
    gin_c      = 1'b0;
    gout_c     = 1'b0;
    dinout_c   = 1'b0;
    sinal_c    = ULA_ADD;
    done_c     = 1'b0;

    case (state_q)
      T0: begin
        irin_c = bus.Run;
        if (bus.Run) state_d = T1;
      end
      T1: begin
        if (opcode == OP_MV) begin
          rout_en_c  = 1'b1;
          rout_sel_c = ry;
          rin_en_c   = 1'b1;
          done_c     = 1'b1;
          state_d    = T0;
        end else if (opcode == OP_MVI) begin
          dinout_c = 1'b1;
          rin_en_c = 1'b1;
          done_c   = 1'b1;
          state_d  = T0;
        end else if (is_alu_op(opcode)) begin
          rout_en_c  = 1'b1;
          rout_sel_c = rx;
          ain_c      = 1'b1;
          state_d    = T2;
        end else begin
          // Undefined opcode: finish without touching any register.
          done_c  = 1'b1;
          state_d = T0;
        end
      end
      T2: begin
        rout_en_c  = 1'b1;
        rout_sel_c = ry;
        gin_c      = 1'b1;
        sinal_c    = ula_code(opcode);
        state_d    = T3;
      end
      T3: begin
        gout_c   = 1'b1;
        rin_en_c = 1'b1;
        done_c   = 1'b1;
        state_d  = T0;
      end
      default: state_d = T0;
    endcase

    // Reset silences every strobe in the same cycle so no partial writeback.
    if (Reset) begin
      irin_c    = 1'b0;
      rin_en_c  = 1'b0;
      rout_en_c = 1'b0;
      ain_c     = 1'b0;
      gin_c     = 1'b0;
      gout_c    = 1'b0;
      dinout_c  = 1'b0;
      sinal_c   = ULA_ADD;
      done_c    = 1'b0;
    end
  end

  // Register write enable always targets Rx.
  dec3to8 u_rin_dec (
    .en  (rin_en_c),
    .sel (rx),
    .y   (bus.Rin)
  );

  // Bus drive select targets Rx or Ry depending on step.
  dec3to8 u_rout_dec (
    .en  (rout_en_c),
    .sel (rout_sel_c),
    .y   (bus.Rout)
  );

  assign bus.IRin   = irin_c;
  assign bus.Ain    = ain_c;
  assign bus.Gin    = gin_c;
  assign bus.Gout   = gout_c;
  assign bus.DINout = dinout_c;
  assign bus.sinal  = sinal_c;
  assign bus.Done   = done_c;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected per-cycle control vectors are
// queued when an instruction is issued and compared as each cycle completes.
module tb_control_unit;

  logic Clock;
  logic Reset;

  control_unit_if cu_if ();

  control_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (cu_if.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] st;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic [2:0] sinal;
    logic       done;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] cur_ir   = 16'h0000;

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] v;
    v = 8'd1 << i;
    return v;
  endfunction

  // ALU op select as listed in the opcode table.
  function automatic logic [2:0] exp_sinal(input logic [3:0] op);
    case (op)
      4'h2:    return 3'b000;
      4'h3:    return 3'b001;
      4'h4:    return 3'b010;
      4'h5:    return 3'b011;
      4'h6:    return 3'b100;
      4'h7:    return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  function automatic exp_t idle_exp(input logic [1:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  // Queue the expected vectors for every cycle of one instruction, T0 first.
  function automatic int push_instr(input logic [15:0] ir);
    exp_t       e;
    logic [3:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    int         n;
    op = ir[15:12];
    rx = ir[11:9];
    ry = ir[8:6];
    e = idle_exp(2'd0); e.irin = 1'b1; sb.push_back(e); n = 1;
    e = idle_exp(2'd1);
    if (op == 4'h0) begin
      e.rout = oh(ry); e.rin = oh(rx); e.done = 1'b1;
      sb.push_back(e); n++;
    end else if (op == 4'h1) begin
      e.dinout = 1'b1; e.rin = oh(rx); e.done = 1'b1;
      sb.push_back(e); n++;
    end else if (op <= 4'h7) begin
      e.rout = oh(rx); e.ain = 1'b1;
      sb.push_back(e);
      e = idle_exp(2'd2); e.rout = oh(ry); e.gin = 1'b1; e.sinal = exp_sinal(op);
      sb.push_back(e);
      e = idle_exp(2'd3); e.gout = 1'b1; e.rin = oh(rx); e.done = 1'b1;
      sb.push_back(e);
      n += 3;
    end else begin
      e.done = 1'b1;
      sb.push_back(e); n++;
    end
    return n;
  endfunction

  // One clock cycle: drive inputs after the edge, then check mid-cycle.
  task automatic step(input logic run, input logic [15:0] ir, input logic rst,
                      input string tag);
    exp_t e;
    exp_t o;
    int   drivers;
    @(posedge Clock);
    #1;
    cu_if.Run = run;
    cu_if.IR  = ir;
    Reset     = rst;
    #1;
    o = {2'(dut.state_q), cu_if.IRin, cu_if.Rin, cu_if.Rout, cu_if.Ain,
         cu_if.Gin, cu_if.Gout, cu_if.DINout, cu_if.sinal, cu_if.Done};
    n_checks++;
    assert (sb.size() > 0) else begin
      n_errors++;
      $error("FAIL %s scoreboard empty observed=%h expected=<entry>", tag, o);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (o === e) else begin
        n_errors++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
    drivers = $countones(cu_if.Rout) + int'(cu_if.Gout) + int'(cu_if.DINout);
    n_checks++;
    assert (drivers <= 1) else begin
      n_errors++;
      $error("FAIL %s_bus_drivers observed=%0d expected=<=1", tag, drivers);
    end
    n_checks++;
    assert ($onehot0(cu_if.Rin)) else begin
      n_errors++;
      $error("FAIL %s_rin_onehot observed=%h expected=onehot0", tag, cu_if.Rin);
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic run_mid,
                           input string tag);
    int n;
    n = push_instr(ir);
    for (int k = 0; k < n; k++)
      step((k == 0) ? 1'b1 : run_mid, (k == 0) ? cur_ir : ir, 1'b0,
           $sformatf("%s_c%0d", tag, k));
    cur_ir = ir;
  endtask

  logic [15:0] alu_ops [6];
  exp_t        e_m;

  initial begin
    Reset     = 1'b1;
    cu_if.Run = 1'b1;
    cu_if.IR  = 16'h0000;

    // Reset held with Run high: everything quiet, state T0.
    sb.push_back(idle_exp(2'd0));
    sb.push_back(idle_exp(2'd0));
    step(1'b1, 16'h0000, 1'b1, "rst0");
    step(1'b1, 16'h0000, 1'b1, "rst1");

    // First cycle after release fetches (IRin); then mvi R1 and mv R2,R1.
    run_instr(16'h1200, 1'b0, "mvi_r1");
    run_instr(16'h0440, 1'b0, "mv_r2_r1");
    run_instr(16'h3740, 1'b0, "sub_r3_r5");

    // Back-to-back ALU sweep, Run held high, including Rx == Ry.
    alu_ops[0] = 16'h2480;
    alu_ops[1] = 16'h3A40;
    alu_ops[2] = 16'h41C0;
    alu_ops[3] = 16'h5F80;
    alu_ops[4] = 16'h68C0;
    alu_ops[5] = 16'h7D00;
    for (int i = 0; i < 6; i++)
      run_instr(alu_ops[i], 1'b1, $sformatf("alu%0d", i));

    sb.push_back(idle_exp(2'd0));
    step(1'b0, cur_ir, 1'b0, "idle0");

    // Undefined opcodes finish in T1 with no loads.
    run_instr(16'h8000, 1'b1, "undef_8000");
    run_instr(16'hFFFF, 1'b0, "undef_ffff");

    // Reset lands in T2 of add R1,R2: Gin suppressed, back to T0, no writeback.
    e_m = idle_exp(2'd0); e_m.irin = 1'b1; sb.push_back(e_m);
    e_m = idle_exp(2'd1); e_m.rout = 8'h02; e_m.ain = 1'b1; sb.push_back(e_m);
    sb.push_back(idle_exp(2'd2));
    step(1'b1, cur_ir, 1'b0, "rstmid_t0");
    step(1'b0, 16'h2280, 1'b0, "rstmid_t1");
    step(1'b0, 16'h2280, 1'b1, "rstmid_t2");
    cur_ir = 16'h2280;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(idle_exp(2'd0));
      step(1'b0, cur_ir, 1'b0, $sformatf("rstmid_after%0d", i));
    end

    // Normal operation resumes after the aborted instruction.
    run_instr(16'h1E00, 1'b0, "mvi_r7");

    n_checks++;
    assert (sb.size() == 0) else begin
      n_errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
